pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Pipeline hazard controller. It provides stage enables, fetch
//               stall and flush controls, operand forwarding selects and a
//               stall cycle counter.
//               Optional macro FORWARD_EN turns on operand forwarding, so that
//               only load-use hazards stall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic [4:0]  ex_rd,
    input  logic [4:0]  mem_rd,
    input  logic [4:0]  wb_rd,
    input  logic        ex_reg_write,
    input  logic        mem_reg_write,
    input  logic        wb_reg_write,
    input  logic        ex_mem_to_reg,
    input  logic        ex_branch_taken,
    input  logic        dmem_req,
    input  logic        dmem_ack,
    output logic        decode_enable,
    output logic        execute_enable,
    output logic        memory_enable,
    output logic        writeback_enable,
    output logic        fetch_stall,
    output logic        fetch_flush,
    output logic        execute_flush,
    output logic [1:0]  fwd_rs,
    output logic [1:0]  fwd_rt,
    output logic [31:0] stall_count
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_STALL  = 2'd1,
        RAW_STALL = 2'd2,
        MEM_WAIT  = 2'd3
    } state_t;

    state_t      r_state_q;
    state_t      w_state_d;
    state_t      w_hazard_state;
    logic        r_branch_pend_q;
    logic        w_branch_pend_d;
    logic [31:0] r_stall_count_q;
    logic [31:0] w_stall_count_d;
    logic        w_mem_hold;
    logic        w_hazard;

    logic w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt;

    // Register 0 is hard-wired to zero, so it never creates a dependency.
    assign w_ex_rs  = id_use_rs && ex_reg_write  && (ex_rd  == id_rs) && (id_rs != 5'd0);
    assign w_ex_rt  = id_use_rt && ex_reg_write  && (ex_rd  == id_rt) && (id_rt != 5'd0);
    assign w_mem_rs = id_use_rs && mem_reg_write && (mem_rd == id_rs) && (id_rs != 5'd0);
    assign w_mem_rt = id_use_rt && mem_reg_write && (mem_rd == id_rt) && (id_rt != 5'd0);

`ifdef FORWARD_EN
    logic w_wb_rs, w_wb_rt;

    assign w_wb_rs        = id_use_rs && wb_reg_write && (wb_rd == id_rs) && (id_rs != 5'd0);
    assign w_wb_rt        = id_use_rt && wb_reg_write && (wb_rd == id_rt) && (id_rt != 5'd0);
    assign w_hazard       = ex_mem_to_reg && (w_ex_rs || w_ex_rt);
    assign w_hazard_state = LU_STALL;

    always_comb begin
        fwd_rs = 2'd0;
        fwd_rt = 2'd0;
        if (!reset) begin
            if (w_ex_rs)       fwd_rs = 2'd1;
            else if (w_mem_rs) fwd_rs = 2'd2;
            else if (w_wb_rs)  fwd_rs = 2'd3;
            if (w_ex_rt)       fwd_rt = 2'd1;
            else if (w_mem_rt) fwd_rt = 2'd2;
            else if (w_wb_rt)  fwd_rt = 2'd3;
        end
    end
`else
    // The register file bypasses same-cycle writes, so writeback never stalls.
    logic w_unused_wb;

    assign w_unused_wb    = ^{wb_rd, wb_reg_write, ex_mem_to_reg};
    assign w_hazard       = w_ex_rs || w_ex_rt || w_mem_rs || w_mem_rt;
    assign w_hazard_state = RAW_STALL;
    assign fwd_rs         = 2'd0;
    assign fwd_rt         = 2'd0;
`endif

    // Once waiting, only the ack releases the pipeline, whatever dmem_req does.
    assign w_mem_hold = (r_state_q == MEM_WAIT) ? !dmem_ack : (dmem_req && !dmem_ack);

    always_comb begin
        decode_enable    = 1'b1;
        execute_enable   = 1'b1;
        memory_enable    = 1'b1;
        writeback_enable = 1'b1;
        fetch_stall      = 1'b0;
        fetch_flush      = 1'b0;
        execute_flush    = 1'b0;
        w_state_d        = RUN;
        w_branch_pend_d  = 1'b0;

        if (reset) begin
            decode_enable    = 1'b0;
            execute_enable   = 1'b0;
            memory_enable    = 1'b0;
            writeback_enable = 1'b0;
        end else if (w_mem_hold) begin
            decode_enable    = 1'b0;
            execute_enable   = 1'b0;
            memory_enable    = 1'b0;
            writeback_enable = 1'b0;
            fetch_stall      = 1'b1;
            w_state_d        = MEM_WAIT;
            w_branch_pend_d  = r_branch_pend_q || ex_branch_taken;
        end else begin
            fetch_flush = ex_branch_taken || r_branch_pend_q;
            if (r_state_q == MEM_WAIT) begin
                w_state_d = RUN;
            end else if (w_hazard && (r_state_q != LU_STALL)) begin
                decode_enable = 1'b0;
                fetch_stall   = 1'b1;
                execute_flush = 1'b1;
                w_state_d     = w_hazard_state;
            end
        end
    end

    assign w_stall_count_d = fetch_stall ? (r_stall_count_q + 32'd1) : r_stall_count_q;
    assign stall_count     = r_stall_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q       <= RUN;
            r_branch_pend_q <= 1'b0;
            r_stall_count_q <= 32'd0;
        end else begin
            r_state_q       <= w_state_d;
            r_branch_pend_q <= w_branch_pend_d;
            r_stall_count_q <= w_stall_count_d;
        end
    end

endmodule

`default_nettype wire
